// File: rtl/fb_scanout_if.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// fb_scanout_if : framebuffer RAM read port between scan-out engine and RAM
// Rev 1.0
// ----------------------------------------------------------------------------
interface fb_scanout_if #(
    parameter int ADDR_W = 14,
    parameter int WORD_W = 16
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [WORD_W-1:0] mem_rdata;

    modport master (
        output mem_addr,
        output mem_rd,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_rd,
        output mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/fb_scanout.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// fb_scanout : VGA raster timing, framebuffer word fetch, pixel serialiser,
//              palette lookup and registered RGB/sync outputs
// Rev 1.0
// ----------------------------------------------------------------------------
module fb_scanout #(
    parameter int WORD_W = 16,
    parameter int BPP    = 1,
    parameter int FB_W   = 512,
    parameter int FB_H   = 256,
    parameter int X0     = 64,
    parameter int Y0     = 112,
    parameter int H_ACT  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_ACT  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33,
    parameter int RD_LAT = 1,
    parameter int ADDR_W = 14
) (
    input  wire              clk,
    input  wire              reset,
    input  wire              pix_en,
    fb_scanout_if.master     mem,
    input  wire              pal_we,
    input  wire [BPP-1:0]    pal_idx,
    input  wire [11:0]       pal_data,
    input  wire [11:0]       border_rgb,
    output logic [3:0]       VGA_R,
    output logic [3:0]       VGA_G,
    output logic [3:0]       VGA_B,
    output logic             VGA_HS,
    output logic             VGA_VS,
    output logic             frame_start
);
    localparam int c_PPW     = WORD_W / BPP;
    localparam int c_WPL     = FB_W / c_PPW;
    localparam int c_H_TOTAL = H_ACT + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOTAL = V_ACT + V_FP + V_SYNC + V_BP;
    localparam int c_HW      = $clog2(c_H_TOTAL);
    localparam int c_VW      = $clog2(c_V_TOTAL);
    localparam int c_PAL_N   = 1 << BPP;

    logic [c_HW-1:0]   r_h;
    logic [c_VW-1:0]   r_v;
    logic [RD_LAT-1:0] r_rd_pipe;
    logic [WORD_W-1:0] r_prefetch;
    logic [WORD_W-1:0] r_shift;
    logic [11:0]       r_pal [c_PAL_N];
    logic [11:0]       r_s1_rgb;
    logic              r_s1_hs;
    logic              r_s1_vs;
    logic [11:0]       r_rgb;
    logic              r_hs;
    logic              r_vs;

    logic [31:0]       w_h;
    logic [31:0]       w_v;
    logic [31:0]       w_v_next;
    logic [31:0]       w_wx;
    logic [31:0]       w_wy;
    logic [31:0]       w_word;
    logic [31:0]       w_pos;
    logic              w_h_last;
    logic              w_v_last;
    logic              w_in_win;
    logic              w_first;
    logic              w_next_in_win;
    logic              w_rd_line;
    logic              w_rd_word;
    logic              w_rd_req;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [WORD_W-1:0] w_src;
    logic [BPP-1:0]    w_pixel;
    logic              w_active;
    logic [11:0]       w_rgb;
    logic              w_hs;
    logic              w_vs;

    // All raster arithmetic is done at 32 bits so parameter comparisons stay width-clean
    assign w_h      = 32'(r_h);
    assign w_v      = 32'(r_v);
    assign w_h_last = (w_h == c_H_TOTAL - 1);
    assign w_v_last = (w_v == c_V_TOTAL - 1);
    assign w_v_next = w_v_last ? 32'd0 : w_v + 32'd1;

    assign w_in_win = (w_h >= X0) && (w_h < X0 + FB_W) &&
                      (w_v >= Y0) && (w_v < Y0 + FB_H);
    assign w_wx     = w_h - X0;
    assign w_wy     = w_v - Y0;
    assign w_word   = w_wx / c_PPW;
    assign w_pos    = w_wx % c_PPW;
    assign w_first  = (w_pos == 32'd0);

    // Word 0 of the next window line is fetched at the start of hblank
    assign w_next_in_win = (w_v_next >= Y0) && (w_v_next < Y0 + FB_H);
    assign w_rd_line     = (w_h == H_ACT) && w_next_in_win;
    assign w_rd_word     = w_in_win && w_first && (w_word + 32'd1 < c_WPL);
    assign w_rd_req      = w_rd_line || w_rd_word;
    assign w_rd_addr     = w_rd_line ? ADDR_W'((w_v_next - Y0) * c_WPL)
                                     : ADDR_W'(w_wy * c_WPL + w_word + 32'd1);

    assign w_src    = w_first ? r_prefetch : r_shift;
    assign w_pixel  = w_src[BPP-1:0];
    assign w_active = (w_h < H_ACT) && (w_v < V_ACT);
    assign w_hs     = !((w_h >= H_ACT + H_FP) && (w_h < H_ACT + H_FP + H_SYNC));
    assign w_vs     = !((w_v >= V_ACT + V_FP) && (w_v < V_ACT + V_FP + V_SYNC));

    always_comb begin
        w_rgb = 12'h000;
        if (w_active) begin
            w_rgb = w_in_win ? r_pal[w_pixel] : border_rgb;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_h         <= '0;
            r_v         <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= pix_en && w_h_last && w_v_last;
            if (pix_en) begin
                if (w_h_last) begin
                    r_h <= '0;
                    r_v <= w_v_last ? '0 : r_v + c_VW'(1);
                end else begin
                    r_h <= r_h + c_HW'(1);
                end
            end
        end
    end

    // Read return is tracked by delaying mem_rd; reset flushes it so late data is dropped
    always_ff @(posedge clk) begin
        if (reset) begin
            mem.mem_rd   <= 1'b0;
            mem.mem_addr <= '0;
            r_rd_pipe    <= '0;
            r_prefetch   <= '0;
        end else begin
            mem.mem_rd <= pix_en && w_rd_req;
            if (pix_en && w_rd_req) begin
                mem.mem_addr <= w_rd_addr;
            end
            r_rd_pipe[0] <= mem.mem_rd;
            for (int i = 1; i < RD_LAT; i++) begin
                r_rd_pipe[i] <= r_rd_pipe[i-1];
            end
            if (r_rd_pipe[RD_LAT-1]) begin
                r_prefetch <= mem.mem_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift  <= '0;
            r_s1_rgb <= 12'h000;
            r_s1_hs  <= 1'b1;
            r_s1_vs  <= 1'b1;
            r_rgb    <= 12'h000;
            r_hs     <= 1'b1;
            r_vs     <= 1'b1;
        end else if (pix_en) begin
            if (w_in_win) begin
                r_shift <= w_src >> BPP;
            end
            r_s1_rgb <= w_rgb;
            r_s1_hs  <= w_hs;
            r_s1_vs  <= w_vs;
            r_rgb    <= r_s1_rgb;
            r_hs     <= r_s1_hs;
            r_vs     <= r_s1_vs;
        end
    end

    // Entry 0 white, rest black: a 1 bit in a mono framebuffer shows as black
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < c_PAL_N; i++) begin
                r_pal[i] <= (i == 0) ? 12'hFFF : 12'h000;
            end
        end else if (pal_we) begin
            r_pal[pal_idx] <= pal_data;
        end
    end

    assign VGA_R  = r_rgb[11:8];
    assign VGA_G  = r_rgb[7:4];
    assign VGA_B  = r_rgb[3:0];
    assign VGA_HS = r_hs;
    assign VGA_VS = r_vs;
endmodule
`default_nettype wire

// File: doc/fb_scanout.md
# fb_scanout

Parametrised framebuffer scan-out engine: generates VGA timing, fetches framebuffer words from a fixed-latency synchronous RAM read port, serialises them into pixels, maps pixel values through a writable colour palette and drives 12-bit RGB plus syncs. It replaces the fixed 512x256 monochrome display path with configurable window size, placement, bits-per-pixel and raster timing. It sits between the framebuffer RAM read port and the VGA pins, in the same clock domain as the RAM.

## Interface
- WORD_W, 16, framebuffer word width in bits
- BPP, 1, bits per pixel (1, 2, 4 or 8; must divide WORD_W)
- FB_W, 512, window width in pixels (multiple of WORD_W/BPP)
- FB_H, 256, window height in lines
- X0, 64 / Y0, 112, window top-left position in active area
- H_ACT 640, H_FP 16, H_SYNC 96, H_BP 48; V_ACT 480, V_FP 10, V_SYNC 2, V_BP 33: raster timing in pixels/lines
- RD_LAT, 1, clocks from mem_rd to valid mem_rdata
- ADDR_W, 14, framebuffer word address width
- Derived: PPW = WORD_W/BPP pixels per word; WPL = FB_W/PPW words per line

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- pix_en  in  1  pixel strobe; all pixel-rate state advances only when high
- mem_addr  out  ADDR_W  word address
- mem_rd  out  1  read strobe, one clk wide
- mem_rdata  in  WORD_W  read data, valid exactly RD_LAT clks after mem_rd
- pal_we  in  1  palette write enable
- pal_idx  in  BPP  palette write index
- pal_data  in  12  palette write value {R,G,B}
- border_rgb  in  12  colour for active area outside window
- VGA_R, VGA_G, VGA_B  out  4 each  colour
- VGA_HS, VGA_VS  out  1  syncs, active-low
- frame_start  out  1  one-clk pulse at start of line 0

## Operation
- Counters h (0..H_TOTAL-1), v (0..V_TOTAL-1); h increments on pix_en, wraps to 0 and increments v; v wraps to 0 after V_TOTAL-1.
- Window: X0 <= h < X0+FB_W and Y0 <= v < Y0+FB_H. wx = h-X0, wy = v-Y0.
- Address: mem_addr = wy*WPL + wx/PPW, computed with ADDR_W-bit wrap; no base offset.
- Pixel i of a word (i = wx mod PPW) is mem_rdata[i*BPP +: BPP]; pixel 0 is LSBs (leftmost on screen).
- Fetch: word 0 of window line wy is read on the pix_en tick where h == H_ACT (start of hblank) of the preceding line; word k+1 is read on the tick where wx mod PPW == 0 for word k. No read for k+1 == WPL; no reads for lines outside the window. mem_rd otherwise 0.
- Returned data lands in a prefetch register, transferred to the shift register when wx mod PPW == 0.
- Palette: 2^BPP x 12-bit registers. Reset: entry 0 = 12'hFFF, all others 12'h000 (Hack polarity). Write takes effect on the clk edge where pal_we=1, independent of pix_en.
- Colour: in window -> palette[pixel]; active outside window -> border_rgb; blanking -> 12'h000.
- HS low for h in [H_ACT+H_FP, H_ACT+H_FP+H_SYNC); VS low for v in [V_ACT+V_FP, V_ACT+V_FP+V_SYNC).

## Timing
- Pipeline: counters -> pixel select/palette lookup -> output register. RGB, HS, VS reflect counter state from 2 pix_en ticks earlier; syncs delayed identically to colour.
- Constraint: RD_LAT+1 <= PPW * (clks per pix_en); fetch always completes before use. No stall path.
- Reset: h=v=0, RGB=0, VGA_HS=VGA_VS=1, mem_rd=0, mem_addr=0, frame_start=0, pipeline cleared, palette to defaults. Reset mid-frame aborts outstanding read; late mem_rdata ignored.
- frame_start: high for one clk on the pix_en tick where counters go to (0,0).
- pix_en low: all counters, pipeline and outputs hold; mem_rd stays 0.
- Palette write and lookup of same entry in same clk: lookup returns old value.

## Test plan
- Reset, then 10 clks with pix_en=0 -> RGB=0, HS=VS=1, mem_rd=0 throughout.
- Default params, pix_en every other clk, RAM word 0 = 16'h0001, others 0 -> pixel (64,112) is 12'h000, (65,112) 12'hFFF; border_rgb=12'hE0F seen at (63,112).
- Timing -> HS low 96 pixels per 800-pixel line, VS low 2 lines per 525, frame_start once per 420000 ticks.
- Address trace -> exactly 32 reads per window line, line wy reads addresses wy*32..wy*32+31 in order, 8192 reads per frame, none outside window.
- BPP=2, pal_idx=3 written 12'h0F0, word 0 = 16'h000C -> pixel (65,112) = 12'h0F0, (64,112) = 12'hFFF.
- Assert reset at h=300, v=200 for one clk -> next pixel state restarts at (0,0); first frame after reset matches reference model pixel-for-pixel.
